imem_loader: RTL

//   Write-side companion of the instruction memory: receives a program image as
//   a byte stream and writes it word by word into the instruction memory's

---
 rtl/imem_loader_if.sv | 21 ++
 rtl/imem_loader.sv | 130 +++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the image loader.
// slave  : loader side (consumes bytes, drives the memory write port)
// master : host/memory side
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory image loader: receives a length-prefixed, MSB-first byte
// stream and writes it word by word into the instruction memory, holding the
// CPU in reset until the image is completely and correctly loaded.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing 32-bit sum check).
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LEN    | collecting the 4-byte word count
// DATA   | collecting data words, one write per completed word
// SUM    | collecting the 4-byte checksum (checksum build only)
// DONE   | image loaded, CPU released
// ERR    | load rejected, CPU held
module imem_loader #(
  parameter int ADDR_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            done,
  output logic            error,
  output logic [ADDR_W:0] words_loaded
);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_SUM, S_DONE, S_ERR} state_t;

  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_SUM;
  logic [31:0] sum;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t          state, state_nxt;
  logic [23:0]     acc;
  logic [1:0]      bcnt;
  logic [ADDR_W:0] n_words;
  logic [ADDR_W:0] wl_inc;
  logic [31:0]     word;
  logic            accept, last_byte, start_ok, len_zero, len_big, last_word;

  // The word completing with the byte on the bus this cycle.
  assign word      = {acc, bus.in_data};
  assign accept    = bus.in_valid && bus.in_ready;
  assign last_byte = accept && (bcnt == 2'd3);
  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign len_zero  = (word == 32'd0);
  assign len_big   = ({1'b0, word} > MAX_WORDS);
  assign wl_inc    = words_loaded + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word = (wl_inc == n_words);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LEN;
      S_LEN: begin
        if (last_byte) begin
          if (len_zero)     state_nxt = S_TAIL;
          else if (len_big) state_nxt = S_ERR;
          else              state_nxt = S_DATA;
        end
      end
      S_DATA: if (last_byte && last_word) state_nxt = S_TAIL;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_SUM: if (last_byte) state_nxt = (word == sum) ? S_DONE : S_ERR;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs; the CPU runs only once an image is accepted.
  always_comb begin
    bus.in_ready = (state == S_LEN) || (state == S_DATA) || (state == S_SUM);
    done         = (state == S_DONE);
    error        = (state == S_ERR);
    cpu_hold     = (state != S_DONE);
  end

  // Byte assembly, length latch and the registered one-cycle memory write.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc           <= '0;
      bcnt          <= '0;
      n_words       <= '0;
      words_loaded  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum           <= '0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      if (start_ok) begin
        bcnt         <= '0;
        words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum          <= '0;
`endif
      end else if (accept) begin
        acc  <= word[23:0];
        bcnt <= bcnt + 2'd1;
        if (bcnt == 2'd3) begin
          // Only meaningful when the length passes the range check.
          if (state == S_LEN) n_words <= word[ADDR_W:0];
          if (state == S_DATA) begin
            bus.mem_we    <= 1'b1;
            bus.mem_wdata <= word;
            bus.mem_addr  <= {{(32-ADDR_W){1'b0}}, words_loaded[ADDR_W-1:0]};
            words_loaded  <= wl_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum           <= sum + word;
`endif
          end
        end
      end
    end
  end

endmodule
